// File: rtl/gates_checker.sv
// In-hardware driver/monitor for a two-input gate block. It walks the four (a,b)
// vectors, lets each one settle, compares y_in against {a&b, a|b, ~a} and reports the results.
module gates_checker #(
  parameter int unsigned SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [2:0] y_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_vec
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DRIVE  = 2'd1,
    S_SAMPLE = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t     state_q;
  logic [1:0] idx_q;
  logic [3:0] cnt_q;
  logic       busy_q;
  logic       done_q;
  logic       pass_q;
  logic [2:0] err_q;
  logic [3:0] fail_q;

  logic [2:0] exp_s;
  logic       match_s;
  logic [2:0] err_d;
  logic [3:0] fail_d;

  function automatic logic [2:0] expected_y(input logic [1:0] idx);
    return {idx[1] & idx[0], idx[1] | idx[0], ~idx[1]};
  endfunction

  // Compare against the expected response; an unknown y_in falls into the mismatch branch.
  always_comb begin
    exp_s = expected_y(idx_q);
    if (y_in == exp_s) begin
      match_s = 1'b1;
    end else begin
      match_s = 1'b0;
    end
    if (match_s) begin
      err_d  = err_q;
      fail_d = fail_q;
    end else begin
      err_d  = err_q + 3'd1;
      fail_d = fail_q | (4'b0001 << idx_q);
    end
  end

  // Sequencer: start/restart, per-vector settle hold, sample and result registration.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= 2'd0;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= 3'd0;
      fail_q  <= 4'd0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start) begin
            state_q <= S_DRIVE;
            idx_q   <= 2'd0;
            cnt_q   <= 4'd0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
            err_q   <= 3'd0;
            fail_q  <= 4'd0;
          end
        end
        S_DRIVE: begin
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == SETTLE_M1) begin
            state_q <= S_SAMPLE;
          end
        end
        S_SAMPLE: begin
          err_q  <= err_d;
          fail_q <= fail_d;
          if (idx_q == 2'd3) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            pass_q  <= (err_d == 3'd0);
          end else begin
            state_q <= S_DRIVE;
            idx_q   <= idx_q + 2'd1;
            cnt_q   <= 4'd0;
          end
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign a_out     = idx_q[1];
  assign b_out     = idx_q[0];
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;
  assign fail_vec  = fail_q;

endmodule

// File: tb/tb_gates_checker.sv
// Bench for gates_checker: three builds (SETTLE=2, 1, 15) driving modelled gate blocks,
// with injectable faults on the SETTLE=2 instance.
module tb_gates_checker;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] start_r;
  logic [2:0] y_w   [3];
  logic [2:0] a_w, b_w, busy_w, done_w, pass_w;
  logic [2:0] err_w [3];
  logic [3:0] fv_w  [3];
  int          mode_r;
  logic [11:0] mask_r;
  int          n_pass  = 0;
  int          n_total = 0;

  always #5 clk = ~clk;

  // Ideal gate block response from plain arithmetic on the vector number.
  function automatic logic [2:0] ideal_y(input int v);
    int a;
    int b;
    a = v / 2;
    b = v % 2;
    return 3'((a & b) * 4 + (a | b) * 2 + (1 - a));
  endfunction

  // Gate block as seen by the checker, with an optional fault applied.
  function automatic logic [2:0] env_y(input int mode, input logic [11:0] mask, input int v);
    logic [2:0] i;
    logic [2:0] m;
    i = ideal_y(v);
    m = mask[3*v +: 3];
    case (mode)
      1:       return i & 3'b110;
      2:       return {i[1], i[2], i[0]};
      3:       return i ^ m;
      default: return i;
    endcase
  endfunction

  assign y_w[0] = env_y(mode_r, mask_r, int'({a_w[0], b_w[0]}));
  assign y_w[1] = ideal_y(int'({a_w[1], b_w[1]}));
  assign y_w[2] = ideal_y(int'({a_w[2], b_w[2]}));

  gates_checker #(.SETTLE(2)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start_r[0]), .y_in(y_w[0]),
    .a_out(a_w[0]), .b_out(b_w[0]), .busy(busy_w[0]), .done(done_w[0]),
    .pass(pass_w[0]), .err_count(err_w[0]), .fail_vec(fv_w[0])
  );
  gates_checker #(.SETTLE(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start_r[1]), .y_in(y_w[1]),
    .a_out(a_w[1]), .b_out(b_w[1]), .busy(busy_w[1]), .done(done_w[1]),
    .pass(pass_w[1]), .err_count(err_w[1]), .fail_vec(fv_w[1])
  );
  gates_checker #(.SETTLE(15)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start_r[2]), .y_in(y_w[2]),
    .a_out(a_w[2]), .b_out(b_w[2]), .busy(busy_w[2]), .done(done_w[2]),
    .pass(pass_w[2]), .err_count(err_w[2]), .fail_vec(fv_w[2])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic run_check(input int k, input int settle, input int mode,
                           input logic [11:0] mask, input bit re_pulse);
    logic [3:0] efv;
    int         eerr;
    int         per;
    int         lat;
    int         idx;
    efv  = 4'd0;
    eerr = 0;
    for (int v = 0; v < 4; v++) begin
      if (env_y(mode, mask, v) != ideal_y(v)) begin
        efv[v] = 1'b1;
        eerr++;
      end
    end
    if (k == 0) begin
      mode_r = mode;
      mask_r = mask;
    end
    per = settle + 1;
    lat = -1;
    @(negedge clk);
    start_r[k] = 1'b1;
    @(negedge clk);
    start_r[k] = 1'b0;
    chk("clear_err", 32'(err_w[k]), 32'd0);
    chk("clear_fv", 32'(fv_w[k]), 32'd0);
    for (int s = 0; s < 400 && lat < 0; s++) begin
      if (done_w[k]) begin
        lat = s;
      end else begin
        idx = s / per;
        if (idx < 4) begin
          chk("drive_seq", 32'({busy_w[k], a_w[k], b_w[k]}), 32'(4 + idx));
        end
        start_r[k] = re_pulse && (s == 2 * per + 1);
        @(negedge clk);
      end
    end
    start_r[k] = 1'b0;
    chk("latency", 32'(lat), 32'(4 * per));
    chk("busy_done", 32'({busy_w[k], done_w[k]}), 32'd1);
    chk("err_count", 32'(err_w[k]), 32'(eerr));
    chk("fail_vec", 32'(fv_w[k]), 32'(efv));
    chk("pass", 32'(pass_w[k]), 32'(eerr == 0));
  endtask

  initial begin
    logic [11:0] m;
    rst_n   = 1'b0;
    start_r = 3'd0;
    mode_r  = 0;
    mask_r  = 12'd0;
    repeat (2) @(negedge clk);
    chk("reset_outs", 32'({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fv_w[0]}), 32'd0);
    rst_n = 1'b1;

    run_check(0, 2, 0, 12'd0, 1'b0);
    run_check(0, 2, 1, 12'd0, 1'b0);
    chk("fv_y0_stuck", 32'(fv_w[0]), 32'b0011);
    run_check(0, 2, 2, 12'd0, 1'b0);
    chk("fv_swap", 32'(fv_w[0]), 32'b0110);
    run_check(0, 2, 1, 12'd0, 1'b1);
    run_check(0, 2, 0, 12'd0, 1'b0);

    // Reset during SAMPLE of vector 1 with a stuck y_in[0]: vector 0 has already failed.
    mode_r = 1;
    @(negedge clk);
    start_r[0] = 1'b1;
    @(negedge clk);
    start_r[0] = 1'b0;
    repeat (5) @(negedge clk);
    chk("pre_reset", 32'({busy_w[0], a_w[0], b_w[0], err_w[0]}), 32'b1_0_1_001);
    rst_n = 1'b0;
    #1;
    chk("async_reset", 32'({a_w[0], b_w[0], busy_w[0], done_w[0], pass_w[0], err_w[0], fv_w[0]}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_reset_idle", 32'({busy_w[0], done_w[0], err_w[0], fv_w[0]}), 32'd0);
    run_check(0, 2, 0, 12'd0, 1'b0);

    run_check(1, 1, 0, 12'd0, 1'b0);
    run_check(2, 15, 0, 12'd0, 1'b0);

    repeat (20) begin
      for (int v = 0; v < 4; v++) begin
        m[3*v +: 3] = ($urandom_range(0, 1) == 1) ? 3'($urandom_range(1, 7)) : 3'd0;
      end
      run_check(0, 2, 3, m, 1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
